// File: rtl/mac_vlg_pkg.sv
// Shared types and defaults for the MAC TX frame arbiter.
package mac_vlg_pkg;

  localparam int unsigned IFG_TICKS_DEF = 12;
  localparam int unsigned MAX_LEN_DEF   = 1518;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    IFG   = 2'd3
  } arb_state_t;

  // $clog2 with a floor of one bit, so single-value fields still get a wire.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/mac_vlg_rr_arb.sv
// Combinational N-way picker: round-robin after ptr (MODE 0) or lowest index (MODE 1).
module mac_vlg_rr_arb
  import mac_vlg_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned MODE = 0,
  localparam int unsigned CH_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt,
  output logic            any
);

  logic        found;
  int unsigned idx;

  // Walk the candidates in priority order and keep the first requester.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (MODE == 0) idx = (32'(ptr) + 32'(k) + 32'd1) % N_CH;
      else           idx = k;
      if (!found && req[CH_W'(idx)]) begin
        found = 1'b1;
        gnt   = CH_W'(idx);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mac_vlg_tx_arb.sv
// Whole-frame arbiter: multiplexes N byte-stream sources onto one MAC TX stream
// with inter-frame gap and maximum-length truncation.
module mac_vlg_tx_arb
  import mac_vlg_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned IFG_TICKS = IFG_TICKS_DEF,
  parameter int unsigned MAX_LEN   = MAX_LEN_DEF,
  parameter int unsigned MODE      = 0,
  localparam int unsigned CH_W     = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_dat,
  input  logic [N_CH-1:0]   in_val,
  input  logic [N_CH-1:0]   in_sof,
  input  logic [N_CH-1:0]   in_eof,
  output logic [N_CH-1:0]   in_rdy,
  output logic [W-1:0]      out_dat,
  output logic              out_val,
  output logic              out_sof,
  output logic              out_eof,
  input  logic              out_rdy,
  output logic [CH_W-1:0]   out_ch,
  output logic              busy,
  output logic              err_len
);

  localparam int unsigned LEN_W = clog2_min1(MAX_LEN + 1);
  localparam int unsigned IFG_W = clog2_min1(IFG_TICKS + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_TICKS - 1);
  localparam arb_state_t POST_FRAME = (IFG_TICKS == 0) ? IDLE : IFG;

  arb_state_t        state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IFG_W-1:0]  ifg_q, ifg_d;
  logic              err_q, err_d;

  logic [N_CH-1:0]   req;
  logic [CH_W-1:0]   pick;
  logic              any_req;
  logic [N_CH-1:0]   gnt_oh;
  logic [W-1:0]      dat_arr [N_CH];
  logic [W-1:0]      g_dat;
  logic              g_val, g_sof, g_eof;

  assign req = in_val & in_sof;

  mac_vlg_rr_arb #(
    .N_CH (N_CH),
    .MODE (MODE)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick),
    .any (any_req)
  );

  // Split the flat data bus into per-channel lanes.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_lane
    assign dat_arr[i] = in_dat[i*W +: W];
  end

  // Signals of the currently granted channel.
  assign gnt_oh = N_CH'(1) << grant_q;
  assign g_dat  = dat_arr[grant_q];
  assign g_val  = in_val[grant_q];
  assign g_sof  = in_sof[grant_q];
  assign g_eof  = in_eof[grant_q];

  // Next-state, counters and combinational stream outputs.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    ifg_d   = ifg_q;
    err_d   = 1'b0;
    in_rdy  = '0;
    out_dat = '0;
    out_val = 1'b0;
    out_sof = 1'b0;
    out_eof = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Stray mid-frame beats are flushed while nobody owns the output.
        in_rdy = in_val & ~in_sof;
        if (any_req) begin
          grant_d = pick;
          ptr_d   = pick;
          len_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        out_dat = g_dat;
        out_val = g_val;
        out_sof = g_sof;
        out_eof = g_eof | (len_q == LEN_LAST);
        in_rdy  = out_rdy ? gnt_oh : '0;
        if (g_val && out_rdy) begin
          if (len_q != LEN_MAX) len_d = len_q + LEN_W'(1);
          if (g_eof) begin
            ifg_d   = '0;
            state_d = POST_FRAME;
          end else if (len_q == LEN_LAST) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Swallow the over-long tail of a truncated frame.
        in_rdy = gnt_oh;
        if (g_val && g_eof) begin
          ifg_d   = '0;
          state_d = POST_FRAME;
        end
      end
      IFG: begin
        if (ifg_q == IFG_LAST) state_d = IDLE;
        else                   ifg_d   = ifg_q + IFG_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (!rst) in_rdy = '0;
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= CH_W'(N_CH - 1);
      len_q   <= '0;
      ifg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      ifg_q   <= ifg_d;
      err_q   <= err_d;
    end
  end

  assign out_ch  = grant_q;
  assign busy    = (state_q != IDLE);
  assign err_len = err_q;

endmodule

// File: doc/mac_vlg_tx_arb.md
Name: mac_vlg_tx_arb

Overview:
- Parametrised N-channel frame arbiter in front of the MAC transmit path. It multiplexes whole Ethernet frames from N_CH independent byte-stream sources onto one MAC TX stream.
- Never interleaves frames. Enforces a programmable inter-frame gap and a maximum frame length, in round-robin or fixed-priority mode.
- Sits between the upper-layer TX sources (IPv4/ARP/raw) and the MAC TX input, in the local 125 MHz clock domain.

Parameters:
- N_CH, 4, number of source channels (1..16).
- W, 8, data width per beat in bits.
- IFG_TICKS, 12, idle cycles forced after each frame's last beat (0 = back-to-back allowed).
- MAX_LEN, 1518, maximum beats per frame before forced truncation.
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  local 125 MHz clock.
- rst  in  1  asynchronous, active-low reset.
- in_dat  in  N_CH*W  channel i data at bits [i*W +: W].
- in_val  in  N_CH  beat valid per channel.
- in_sof  in  N_CH  first beat of frame.
- in_eof  in  N_CH  last beat of frame.
- in_rdy  out  N_CH  beat accepted when in_val[i] & in_rdy[i].
- out_dat  out  W  granted channel data.
- out_val  out  1  output beat valid.
- out_sof  out  1  first beat.
- out_eof  out  1  last beat (natural or forced).
- out_rdy  in  1  MAC accepts beat when out_val & out_rdy.
- out_ch  out  $clog2(N_CH) (min 1)  index of granted channel, stable for the whole frame.
- busy  out  1  high in any state other than IDLE.
- err_len  out  1  one-cycle pulse on forced truncation.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; RR pointer = N_CH-1 so ch0 is served first; length and IFG counters 0.
- A channel requests when in_val[i] & in_sof[i].
- States:
  - IDLE:
    - in_rdy[i]=1 for channels with in_val & !in_sof (stray beats flushed and discarded); 0 otherwise.
    - If any request: register grant and out_ch, pointer=grant, go to XFER.
    - Latency is 1 cycle from request to first out_val.
  - XFER:
    - Combinational pass-through: out_dat/out_val/out_sof/out_eof follow the granted channel.
    - in_rdy[grant]=out_rdy; all other in_rdy=0.
    - len counter increments on each accepted beat.
    - Accepted beat with in_eof goes to IFG, or to IDLE if IFG_TICKS=0.
    - Accepted beat number MAX_LEN without in_eof: out_eof forced to 1 on that beat, err_len pulses next cycle, go to DRAIN.
    - eof exactly on beat MAX_LEN is a normal frame: no error.
  - DRAIN:
    - out_val=0; in_rdy[grant]=1.
    - Discard beats until an in_eof beat is accepted, then go to IFG.
  - IFG:
    - out_val=0; all in_rdy=0.
    - Count IFG_TICKS cycles, then go to IDLE.
- Arbitration:
  - MODE 0: search from pointer+1 upward, wrapping modulo N_CH; first requester wins.
  - MODE 1: lowest requesting index wins; pointer is ignored.
- Backpressure: out_rdy=0 holds the current beat. The source sees in_rdy=0, so data must stay stable; no beat is lost or duplicated.
- Source drops in_val mid-frame in XFER: out_val=0, state held, no timeout.
- New in_sof on the granted channel mid-frame in XFER: passed through unchanged; framing is owned by the source.
- Reset asserted mid-frame: immediate return to IDLE with outputs 0; the partial frame is abandoned, with no eof emitted.
- Width rules:
  - len counter is $clog2(MAX_LEN+1) bits and saturates at MAX_LEN.
  - IFG counter is $clog2(IFG_TICKS+1) bits.

Decomposition:
- mac_vlg_pkg gains the arb_state_t enum {IDLE, XFER, DRAIN, IFG} and the default constants for IFG_TICKS and MAX_LEN.
- Sub-module mac_vlg_rr_arb:
  - combinational N-way picker with MODE select;
  - inputs: request vector and pointer;
  - outputs: grant index and any-request flag.
- Instantiated once inside mac_vlg_tx_arb.

Test Plan:
- Reset then ch2 sends a 64-beat frame, others idle, out_rdy=1 -> out_ch=2, out_sof on beat 1, out_eof on beat 64, busy high, then exactly 12 idle cycles before IDLE.
- ch0, ch1 and ch3 all request continuously, MODE=0 -> grant order 0,1,3,0,1,3; each frame is contiguous with no interleaving.
- Same stimulus with MODE=1 -> ch0 wins every arbitration; ch1 and ch3 are starved while ch0 keeps requesting.
- MAX_LEN=100, ch1 sends 150 beats -> out_eof forced on beat 100, err_len pulses once, ch1 beats 101-150 are accepted with out_val=0, then IFG.
- out_rdy toggled at random 50% during a 20-beat frame -> output byte sequence identical to input, 20 handshakes, no duplicates.
- Stray in_val without in_sof on ch3 in IDLE -> accepted and discarded, out_val stays 0; a 200-cycle frame on ch1 is interrupted by rst=0 at cycle 30 -> all outputs 0 at once, next grant goes to ch0 first.
